// File: rtl/usb_rx_rcu.sv
// USB RX receive control unit: sync check, PID capture, unstuffed byte assembly, EOP alignment.
// Optional PID check/complement validation is enabled by defining RX_PID_CHECK_EN.
module usb_rx_rcu #(
    parameter int         MAX_BYTES = 64,
    parameter logic [7:0] SYNC_BYTE = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sop,
    input  logic       bit_strobe,
    input  logic       bit_in,
    input  logic       eop,
    output logic       rcving,
    output logic [3:0] rx_pid,
    output logic       pid_valid,
    output logic [7:0] rx_byte,
    output logic       w_enable,
    output logic [6:0] byte_count,
    output logic       rx_done,
    output logic       r_error
);

    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, EOP_WAIT, DONE, ERR} state_t;

    state_t     r_state;
    logic [7:0] r_shreg;
    logic [2:0] r_bit_cnt;
    logic [2:0] r_ones_cnt;
    logic       r_eop_seen;

    logic [7:0] w_next_byte;
    logic       w_last_bit;
    logic       w_stuff;
    logic       w_pid_ok;

    assign w_next_byte = {bit_in, r_shreg[7:1]};
    assign w_last_bit  = (r_bit_cnt == 3'd7);
    assign w_stuff     = (r_ones_cnt == 3'd6);

`ifdef RX_PID_CHECK_EN
    assign w_pid_ok = (w_next_byte[7:4] == ~w_next_byte[3:0]);
`else
    assign w_pid_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_ones_cnt <= '0;
            r_eop_seen <= 1'b0;
            rcving     <= 1'b0;
            rx_pid     <= '0;
            pid_valid  <= 1'b0;
            rx_byte    <= '0;
            w_enable   <= 1'b0;
            byte_count <= '0;
            rx_done    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            pid_valid <= 1'b0;
            w_enable  <= 1'b0;
            rx_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    // sop wins over a coincident strobe; that bit is dropped
                    if (sop) begin
                        r_state    <= SYNC;
                        rcving     <= 1'b1;
                        r_bit_cnt  <= '0;
                        r_ones_cnt <= '0;
                        byte_count <= '0;
                        r_error    <= 1'b0;
                        r_eop_seen <= 1'b0;
                    end
                end
                SYNC: begin
                    if (bit_strobe) begin
                        if (eop) begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                        end else begin
                            r_shreg   <= w_next_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                if (w_next_byte == SYNC_BYTE) begin
                                    r_state <= PID;
                                end else begin
                                    r_state <= ERR;
                                    r_error <= 1'b1;
                                end
                            end
                        end
                    end
                end
                PID, DATA: begin
                    if (bit_strobe) begin
                        if (eop) begin
                            if (r_state == DATA && r_bit_cnt == 3'd0) begin
                                r_state <= EOP_WAIT;
                            end else begin
                                r_state <= ERR;
                                r_error <= 1'b1;
                            end
                        end else if (w_stuff) begin
                            // stuffed bit: dropped, must be a zero
                            r_ones_cnt <= '0;
                            if (bit_in) begin
                                r_state <= ERR;
                                r_error <= 1'b1;
                            end
                        end else begin
                            r_shreg    <= w_next_byte;
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            r_ones_cnt <= bit_in ? r_ones_cnt + 3'd1 : 3'd0;
                            if (w_last_bit) begin
                                if (r_state == PID) begin
                                    if (w_pid_ok) begin
                                        rx_pid    <= w_next_byte[3:0];
                                        pid_valid <= 1'b1;
                                        r_state   <= DATA;
                                    end else begin
                                        r_state <= ERR;
                                        r_error <= 1'b1;
                                    end
                                end else if (byte_count == 7'(MAX_BYTES)) begin
                                    r_state <= ERR;
                                    r_error <= 1'b1;
                                end else begin
                                    rx_byte    <= w_next_byte;
                                    w_enable   <= 1'b1;
                                    byte_count <= byte_count + 7'd1;
                                end
                            end
                        end
                    end
                end
                EOP_WAIT: begin
                    if (bit_strobe && !eop) r_state <= DONE;
                end
                DONE: begin
                    rx_done <= 1'b1;
                    rcving  <= 1'b0;
                    r_state <= IDLE;
                end
                ERR: begin
                    // drain the rest of the packet: SE0 then J
                    if (bit_strobe) begin
                        if (eop) begin
                            r_eop_seen <= 1'b1;
                        end else if (r_eop_seen) begin
                            r_state <= IDLE;
                            rcving  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    rcving  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_rcu.sv
// Directed self-checking bench for usb_rx_rcu (built with MAX_BYTES=2).
module tb_usb_rx_rcu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sop = 1'b0;
    logic       bit_strobe = 1'b0;
    logic       bit_in = 1'b0;
    logic       eop = 1'b0;
    logic       rcving;
    logic [3:0] rx_pid;
    logic       pid_valid;
    logic [7:0] rx_byte;
    logic       w_enable;
    logic [6:0] byte_count;
    logic       rx_done;
    logic       r_error;

    usb_rx_rcu #(.MAX_BYTES(2), .SYNC_BYTE(8'h80)) dut (
        .clk(clk), .rst(rst), .sop(sop), .bit_strobe(bit_strobe), .bit_in(bit_in), .eop(eop),
        .rcving(rcving), .rx_pid(rx_pid), .pid_valid(pid_valid), .rx_byte(rx_byte),
        .w_enable(w_enable), .byte_count(byte_count), .rx_done(rx_done), .r_error(r_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pid = 0;
    int n_wen = 0;
    int n_done = 0;
    int b_pid, b_wen, b_done;
    logic [7:0] wb [0:31];

    // pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (pid_valid) n_pid = n_pid + 1;
        if (w_enable) begin
            wb[n_wen % 32] = rx_byte;
            n_wen = n_wen + 1;
        end
        if (rx_done) n_done = n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_sop(input logic with_bit);
        @(negedge clk);
        sop = 1'b1; bit_strobe = with_bit; bit_in = 1'b1; eop = 1'b0;
        @(negedge clk);
        sop = 1'b0; bit_strobe = 1'b0;
        #1;
    endtask

    task automatic send_bit(input logic b, input logic e);
        @(negedge clk);
        bit_strobe = 1'b1; bit_in = b; eop = e;
        @(negedge clk);
        bit_strobe = 1'b0; eop = 1'b0;
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    endtask

    task automatic end_pkt();
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic snap();
        b_pid = n_pid; b_wen = n_wen; b_done = n_done;
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {8'd0, rcving, rx_pid, pid_valid, rx_byte, w_enable, byte_count, rx_done, r_error}, 32'd0);
        rst = 1'b0;

        // clean packet; the strobe coincident with sop must be ignored
        snap();
        do_sop(1'b1);
        chk("sop_rcving", rcving, 1);
        send_byte(8'h80);
        send_byte(8'hC3);
        chk("clean_pid_pulse", n_pid - b_pid, 1);
        chk("clean_rx_pid", rx_pid, 4'h3);
        send_byte(8'h11);
        send_byte(8'h22);
        chk("clean_wen_count", n_wen - b_wen, 2);
        chk("clean_byte0", wb[(n_wen - 2) % 32], 8'h11);
        chk("clean_byte1", wb[(n_wen - 1) % 32], 8'h22);
        chk("clean_byte_count", byte_count, 2);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        chk("clean_done_early", rx_done, 0);
        @(negedge clk); #1;
        chk("clean_done_latency", rx_done, 1);
        chk("clean_rcving_drop", rcving, 0);
        chk("clean_done_count", n_done - b_done, 1);
        chk("clean_error", r_error, 0);

        // bad sync
        snap();
        do_sop(1'b0);
        send_byte(8'h81);
        chk("badsync_error", r_error, 1);
        chk("badsync_rcving", rcving, 1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        chk("badsync_idle", rcving, 0);
        chk("badsync_sticky", r_error, 1);
        chk("badsync_no_pid", n_pid - b_pid, 0);

        // next sop clears error; stuffed 0xFF data byte
        snap();
        do_sop(1'b0);
        chk("sop_clears_error", r_error, 0);
        send_byte(8'h80);
        send_byte(8'hC3);
        send_byte(8'h11);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("stuff_wen_count", n_wen - b_wen, 2);
        chk("stuff_byte", wb[(n_wen - 1) % 32], 8'hFF);
        chk("stuff_no_error", r_error, 0);
        end_pkt();
        chk("stuff_done", n_done - b_done, 1);

        // stuff bit of 1
        snap();
        do_sop(1'b0);
        send_byte(8'h80);
        send_byte(8'hC3);
        send_byte(8'h11);
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
        chk("badstuff_error", r_error, 1);
        chk("badstuff_wen", n_wen - b_wen, 1);
        end_pkt();
        chk("badstuff_idle", rcving, 0);

        // misaligned EOP after 3 data bits
        snap();
        do_sop(1'b0);
        send_byte(8'h80);
        send_byte(8'hC3);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        chk("misalign_error", r_error, 1);
        end_pkt();
        chk("misalign_wen", n_wen - b_wen, 0);
        chk("misalign_no_done", n_done - b_done, 0);
        chk("misalign_idle", rcving, 0);

        // overflow with MAX_BYTES=2
        snap();
        do_sop(1'b0);
        send_byte(8'h80);
        send_byte(8'hC3);
        send_byte(8'h11);
        send_byte(8'h22);
        chk("ovf_pre_error", r_error, 0);
        send_byte(8'h33);
        chk("ovf_error", r_error, 1);
        chk("ovf_wen", n_wen - b_wen, 2);
        chk("ovf_byte_count", byte_count, 2);
        end_pkt();
        chk("ovf_no_done", n_done - b_done, 0);

        // reset mid-packet
        do_sop(1'b0);
        send_byte(8'h80);
        send_byte(8'hC3);
        send_byte(8'h11);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("midpkt_byte_count", byte_count, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("midpkt_reset_outputs", {8'd0, rcving, rx_pid, pid_valid, rx_byte, w_enable, byte_count, rx_done, r_error}, 32'd0);
        rst = 1'b0;
        send_bit(1'b1, 1'b0);
        chk("post_reset_idle", rcving, 0);
        snap();
        do_sop(1'b0);
        send_byte(8'h80);
        send_byte(8'hC3);
        chk("post_reset_pid", n_pid - b_pid, 1);
        chk("post_reset_rx_pid", rx_pid, 4'h3);
        end_pkt();
        chk("post_reset_done", n_done - b_done, 1);

        // PID whose check nibble is not the complement
        snap();
        do_sop(1'b0);
        send_byte(8'h80);
        send_byte(8'hC4);
`ifdef RX_PID_CHECK_EN
        chk("pidchk_error", r_error, 1);
        chk("pidchk_no_pulse", n_pid - b_pid, 0);
        chk("pidchk_rx_pid_kept", rx_pid, 4'h3);
`else
        chk("pidchk_error", r_error, 0);
        chk("pidchk_pulse", n_pid - b_pid, 1);
        chk("pidchk_rx_pid", rx_pid, 4'h4);
`endif
        end_pkt();
        chk("final_idle", rcving, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_rx_rcu.md
Name: usb_rx_rcu

Overview:
- Receive control unit for the CDL USB RX path. It sits directly after the NRZI decoder and edge/bit-timing logic.
- Consumes the decoded bit stream, per-bit strobes, SOP pulses and EOP flags.
- Sequences packet reception: sync check, PID capture, byte assembly with bit unstuffing, EOP alignment, error handling.
- Emits byte-write strobes toward the RX FIFO and status toward the protocol layer.

Parameters:
- MAX_BYTES, 64: maximum data bytes after the PID. One more completed byte is an overflow error.
- SYNC_BYTE, 8'h80: expected decoded sync byte, assembled LSB-first.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sop  in  1  1-cycle pulse: first K transition out of idle
- bit_strobe  in  1  1-cycle pulse: bit_in/eop valid this cycle
- bit_in  in  1  decoded bit value
- eop  in  1  SE0 currently sampled by decoder
- rcving  out  1  high from accepted sop until return to IDLE
- rx_pid  out  4  captured PID (low nibble of PID byte)
- pid_valid  out  1  1-cycle pulse when rx_pid updates
- rx_byte  out  8  assembled data byte
- w_enable  out  1  1-cycle pulse: rx_byte valid, write FIFO
- byte_count  out  7  data bytes written this packet
- rx_done  out  1  1-cycle pulse: clean packet end
- r_error  out  1  sticky error flag

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-high (clk, rst). rst dominates every other input.
  - Reset values: state=IDLE; all outputs 0; internal shift register, bit count and ones count are 0.
- States: IDLE, SYNC, PID, DATA, EOP_WAIT, DONE, ERR.
- Shift register: 8 bits. Each accepted bit does shreg <= {bit_in, shreg[7:1]} (LSB-first). bit_cnt is 0..7 and wraps to 0 when a byte completes.
- Bit unstuffing (PID and DATA only):
  - ones_cnt increments on each accepted 1 and clears on each accepted 0.
  - When ones_cnt==6, the next strobed bit is the stuff bit. It is not shifted and not counted, and ones_cnt clears.
  - A stuff bit of 1 is an error: go to ERR.
- Error handling: any error sets r_error. r_error stays 1 until the next sop is accepted in IDLE.
- IDLE:
  - rcving=0.
  - On sop: go to SYNC, clear bit_cnt/ones_cnt/byte_count, clear r_error.
  - sop in any other state is ignored.
- SYNC:
  - Shift 8 strobed bits, no unstuffing.
  - On the 8th bit: assembled byte==SYNC_BYTE goes to PID, otherwise ERR.
  - eop=1 at any strobe goes to ERR.
- PID:
  - Shift 8 bits with unstuffing. eop at a strobe goes to ERR.
  - On completion: rx_pid <= byte[3:0], pid_valid pulses the next cycle, go to DATA.
- DATA:
  - Each completed byte registers rx_byte; w_enable pulses 1 cycle, one clock after the 8th bit strobe; byte_count increments in the same cycle.
  - A completed byte when byte_count==MAX_BYTES goes to ERR. No w_enable for that byte.
  - eop=1 at a strobe with bit_cnt==0 goes to EOP_WAIT.
  - eop=1 at a strobe with bit_cnt!=0 goes to ERR. The partial byte is discarded.
- EOP_WAIT: at the first strobe with eop=0 (J), go to DONE.
- DONE: rx_done=1 for 1 cycle, then IDLE.
- ERR:
  - rcving stays 1. Wait for a strobe with eop=1, then a later strobe with eop=0, then go to IDLE.
  - A packet already in EOP_WAIT when the error occurs needs only the eop=0 strobe.
- Simultaneous events:
  - bit_strobe and sop in the same cycle in IDLE: sop is taken and the bit is ignored.
  - Outputs are registered; no combinational path from inputs to outputs.
- Latencies:
  - sop to rcving=1: 1 clk.
  - Final EOP J strobe to rx_done: 2 clk.
  - Return to IDLE to rcving=0: same edge.

Optional Feature:
- Macro: RX_PID_CHECK_EN.
- Defined:
  - At PID completion, require byte[7:4]==~byte[3:0].
  - On mismatch: go to ERR, no pid_valid pulse, rx_pid unchanged.
- Undefined: no check; any PID byte is accepted.

Test Plan:
- Clean packet: sop, sync 0x80, PID 0xC3, bytes 0x11,0x22, eop on byte boundary, then J.
  - Response: pid_valid with rx_pid=3; w_enable ×2 carrying 0x11, 0x22; byte_count=2; rx_done ×1; r_error=0.
- Bad sync: sop, first byte 0x81.
  - Response: ERR, r_error=1, no pid_valid.
  - After eop/J: IDLE, rcving=0. The next sop clears r_error.
- Stuffing: data byte 0xFF carried as 1,1,1,1,1,1,0(stuff),1,1.
  - Response: w_enable with rx_byte=0xFF.
  - Same sequence with the stuff bit=1: r_error=1.
- Misaligned EOP: eop after 3 bits of a data byte.
  - Response: r_error=1, no w_enable for that byte, no rx_done.
- Overflow: MAX_BYTES=2, send 3 data bytes.
  - Response: 2 w_enable pulses, then r_error=1 on the 3rd byte.
- Reset mid-packet: rst=1 during DATA.
  - Response: next clk all outputs 0, state IDLE.
  - With RX_PID_CHECK_EN defined, PID 0xC4 gives r_error=1 and no pid_valid.
